// File: rtl/am9150_pkg.sv
// Shared types and constants for the synchronous AM9150-style RAM model.
package am9150_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 10;
  localparam int unsigned DEFAULT_DATA_WIDTH = 4;
  localparam logic        DEFAULT_CLEAR_BIT  = 1'b0;

endpackage

// File: rtl/am9150_clear_seq.sv
// Clear sweep sequencer: walks every address once per sweep and reports busy.
module am9150_clear_seq
  import am9150_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_req,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  clr_we,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;

  // Request is only honoured from IDLE; a held request restarts after one IDLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR_ON_RESET ? CLEAR : IDLE;
      cnt   <= '0;
      busy  <= CLEAR_ON_RESET;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          cnt <= cnt + ADDR_WIDTH'(1);
          if (cnt == LAST_ADDR) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_addr = cnt;
  assign clr_we   = (state == CLEAR);

endmodule

// File: rtl/am9150_ram_sync.sv
// Synchronous separate-I/O RAM with registered write-through reads and a clear sweep.
module am9150_ram_sync
  import am9150_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = {DATA_WIDTH{DEFAULT_CLEAR_BIT}},
  parameter bit                    CLEAR_ON_RESET = 1'b1
) (
  input  logic                  sysclk,
  input  logic                  sys_rst_n,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  S_n,
  input  logic                  W_n,
  input  logic                  G_n,
  input  logic                  R_n,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  QV,
  output logic                  BUSY
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] q_reg;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clr_we;
  logic                  acc;

  am9150_clear_seq #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk      (sysclk),
    .rst_n    (sys_rst_n),
    .clr_req  (!R_n),
    .clr_addr (clr_addr),
    .clr_we   (clr_we),
    .busy     (BUSY)
  );

  // A clear request in IDLE wins over any access issued in the same cycle.
  assign acc = !BUSY && R_n && !S_n;

  // Storage survives reset; only a sweep changes it besides normal writes.
  always_ff @(posedge sysclk) begin
    if (clr_we) begin
      mem[clr_addr] <= CLEAR_VALUE;
    end else if (acc && !W_n) begin
      mem[A] <= D;
    end
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      q_reg <= '0;
      QV    <= 1'b0;
    end else begin
      QV <= acc;
      if (acc) begin
        q_reg <= W_n ? mem[A] : D;
      end
    end
  end

  assign Q = G_n ? {DATA_WIDTH{1'bz}} : q_reg;

endmodule

// File: tb/tb_am9150_ram_sync.sv
// Directed bench: a 16-word auto-clearing instance and a 1K manual-clear instance.
module tb_am9150_ram_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // Instance A: ADDR_WIDTH=4, CLEAR_ON_RESET=1
  logic       a_rst_n;
  logic [3:0] a_A;
  logic [3:0] a_D;
  logic       a_S_n, a_W_n, a_G_n, a_R_n;
  wire  [3:0] a_Q;
  logic       a_QV, a_BUSY;

  // Instance B: ADDR_WIDTH=10, CLEAR_ON_RESET=0
  logic       b_rst_n;
  logic [9:0] b_A;
  logic [3:0] b_D;
  logic       b_S_n, b_W_n, b_G_n, b_R_n;
  wire  [3:0] b_Q;
  logic       b_QV, b_BUSY;

  am9150_ram_sync #(
    .ADDR_WIDTH     (4),
    .DATA_WIDTH     (4),
    .CLEAR_VALUE    (4'h0),
    .CLEAR_ON_RESET (1'b1)
  ) dut_a (
    .sysclk    (clk),
    .sys_rst_n (a_rst_n),
    .A         (a_A),
    .D         (a_D),
    .S_n       (a_S_n),
    .W_n       (a_W_n),
    .G_n       (a_G_n),
    .R_n       (a_R_n),
    .Q         (a_Q),
    .QV        (a_QV),
    .BUSY      (a_BUSY)
  );

  am9150_ram_sync #(
    .ADDR_WIDTH     (10),
    .DATA_WIDTH     (4),
    .CLEAR_VALUE    (4'h0),
    .CLEAR_ON_RESET (1'b0)
  ) dut_b (
    .sysclk    (clk),
    .sys_rst_n (b_rst_n),
    .A         (b_A),
    .D         (b_D),
    .S_n       (b_S_n),
    .W_n       (b_W_n),
    .G_n       (b_G_n),
    .R_n       (b_R_n),
    .Q         (b_Q),
    .QV        (b_QV),
    .BUSY      (b_BUSY)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    step();
    vectors++;
    if (a_BUSY !== 1'b1 || a_QV !== 1'b0 || a_Q !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_a: busy=%b qv=%b q=%h expected busy=1 qv=0 q=0", a_BUSY, a_QV, a_Q);
    end
    vectors++;
    if (b_BUSY !== 1'b0 || b_QV !== 1'b0 || b_Q !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_b: busy=%b qv=%b q=%h expected busy=0 qv=0 q=0", b_BUSY, b_QV, b_Q);
    end
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    n = 0;
    while (a_BUSY && n < 100) begin
      n++;
      step();
    end
    vectors++;
    if (n != 16) begin
      miscompares++;
      $display("FAIL reset_sweep_len: busy cycles=%0d expected 16", n);
    end
    vectors++;
    if (b_BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL no_auto_clear_b: busy=%b expected 0", b_BUSY);
    end
    for (int i = 0; i < 16; i++) begin
      a_A = 4'(i); a_S_n = 1'b0; a_W_n = 1'b1;
      step();
      vectors++;
      if (a_QV !== 1'b1 || a_Q !== 4'h0) begin
        miscompares++;
        $display("FAIL post_sweep_read[%0d]: qv=%b q=%h expected qv=1 q=0", i, a_QV, a_Q);
      end
    end
    a_S_n = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    b_A = 10'h3FF; b_D = 4'hA; b_S_n = 1'b0; b_W_n = 1'b0;
    step();
    vectors++;
    if (b_QV !== 1'b1 || b_Q !== 4'hA) begin
      miscompares++;
      $display("FAIL write_through: qv=%b q=%h expected qv=1 q=a", b_QV, b_Q);
    end
    b_A = 10'h3FE; b_D = 4'h3;
    step();
    vectors++;
    if (b_QV !== 1'b1 || b_Q !== 4'h3) begin
      miscompares++;
      $display("FAIL back_to_back_write: qv=%b q=%h expected qv=1 q=3", b_QV, b_Q);
    end
    b_A = 10'h3FF; b_W_n = 1'b1;
    step();
    vectors++;
    if (b_QV !== 1'b1 || b_Q !== 4'hA) begin
      miscompares++;
      $display("FAIL read_3ff: qv=%b q=%h expected qv=1 q=a", b_QV, b_Q);
    end
    b_A = 10'h3FE;
    step();
    vectors++;
    if (b_QV !== 1'b1 || b_Q !== 4'h3) begin
      miscompares++;
      $display("FAIL read_3fe: qv=%b q=%h expected qv=1 q=3", b_QV, b_Q);
    end
    b_S_n = 1'b1;
    step();
    vectors++;
    if (b_QV !== 1'b0 || b_Q !== 4'h3) begin
      miscompares++;
      $display("FAIL deselect_hold: qv=%b q=%h expected qv=0 q=3", b_QV, b_Q);
    end
  endtask

  task automatic test_output_enable();
    b_G_n = 1'b1; b_A = 10'h3FF; b_S_n = 1'b0; b_W_n = 1'b1;
    step();
    vectors++;
    if (b_QV !== 1'b1 || b_Q === 4'hA) begin
      miscompares++;
      $display("FAIL oe_off: qv=%b q=%h expected qv=1 and q not driven", b_QV, b_Q);
    end
    b_S_n = 1'b1;
    b_G_n = 1'b0;
    #1;
    vectors++;
    if (b_Q !== 4'hA) begin
      miscompares++;
      $display("FAIL oe_on: q=%h expected a", b_Q);
    end
    step();
  endtask

  task automatic test_clear_drop();
    int n;
    a_S_n = 1'b0; a_W_n = 1'b0; a_D = 4'h5;
    for (int i = 0; i < 16; i++) begin
      a_A = 4'(i);
      step();
    end
    a_A = 4'h6; a_W_n = 1'b1;
    step();
    vectors++;
    if (a_QV !== 1'b1 || a_Q !== 4'h5) begin
      miscompares++;
      $display("FAIL fill_read: qv=%b q=%h expected qv=1 q=5", a_QV, a_Q);
    end
    a_A = 4'h7; a_D = 4'h9; a_W_n = 1'b0; a_R_n = 1'b0;
    step();
    vectors++;
    if (a_BUSY !== 1'b1 || a_QV !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_start: busy=%b qv=%b expected busy=1 qv=0", a_BUSY, a_QV);
    end
    a_R_n = 1'b1; a_S_n = 1'b1; a_W_n = 1'b1;
    n = 0;
    while (a_BUSY && n < 100) begin
      n++;
      step();
    end
    vectors++;
    if (n != 16) begin
      miscompares++;
      $display("FAIL clear_sweep_len: busy cycles=%0d expected 16", n);
    end
    a_S_n = 1'b0; a_A = 4'h7;
    step();
    vectors++;
    if (a_QV !== 1'b1 || a_Q !== 4'h0) begin
      miscompares++;
      $display("FAIL dropped_write: qv=%b q=%h expected qv=1 q=0", a_QV, a_Q);
    end
    a_A = 4'hF;
    step();
    vectors++;
    if (a_Q !== 4'h0) begin
      miscompares++;
      $display("FAIL last_word_cleared: q=%h expected 0", a_Q);
    end
    a_S_n = 1'b1;
    step();
  endtask

  task automatic test_hold_clear();
    int n;
    a_R_n = 1'b0; a_S_n = 1'b0; a_W_n = 1'b0; a_A = 4'h2; a_D = 4'hC;
    step();
    n = 0;
    while (a_BUSY && n < 100) begin
      n++;
      step();
    end
    vectors++;
    if (n != 16) begin
      miscompares++;
      $display("FAIL hold_sweep1_len: busy cycles=%0d expected 16", n);
    end
    step();
    vectors++;
    if (a_BUSY !== 1'b1 || a_QV !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_gap: busy=%b qv=%b expected busy=1 qv=0 after one idle cycle", a_BUSY, a_QV);
    end
    a_R_n = 1'b1;
    n = 0;
    while (a_BUSY && n < 100) begin
      n++;
      step();
    end
    vectors++;
    if (n != 16) begin
      miscompares++;
      $display("FAIL hold_sweep2_len: busy cycles=%0d expected 16", n);
    end
    a_W_n = 1'b1;
    step();
    vectors++;
    if (a_QV !== 1'b1 || a_Q !== 4'h0) begin
      miscompares++;
      $display("FAIL sweep_write_ignored: qv=%b q=%h expected qv=1 q=0", a_QV, a_Q);
    end
    a_S_n = 1'b1;
    step();
  endtask

  task automatic test_reset_midsweep();
    b_S_n = 1'b0; b_W_n = 1'b1; b_A = 10'h3FF;
    step();
    b_S_n = 1'b1;
    b_rst_n = 1'b0;
    #1;
    vectors++;
    if (b_QV !== 1'b0 || b_Q !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_mid_access: qv=%b q=%h expected qv=0 q=0", b_QV, b_Q);
    end
    b_rst_n = 1'b1;
    b_S_n = 1'b0; b_W_n = 1'b0; b_D = 4'h5;
    for (int i = 0; i < 11; i++) begin
      b_A = 10'(i);
      step();
    end
    b_S_n = 1'b1; b_W_n = 1'b1; b_R_n = 1'b0;
    step();
    vectors++;
    if (b_BUSY !== 1'b1) begin
      miscompares++;
      $display("FAIL b_clear_start: busy=%b expected 1", b_BUSY);
    end
    b_R_n = 1'b1;
    repeat (5) step();
    b_rst_n = 1'b0;
    #1;
    vectors++;
    if (b_BUSY !== 1'b0 || b_QV !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_sweep: busy=%b qv=%b expected busy=0 qv=0", b_BUSY, b_QV);
    end
    b_rst_n = 1'b1;
    b_S_n = 1'b0; b_A = 10'd4;
    step();
    vectors++;
    if (b_QV !== 1'b1 || b_Q !== 4'h0) begin
      miscompares++;
      $display("FAIL word4_cleared: qv=%b q=%h expected qv=1 q=0", b_QV, b_Q);
    end
    b_A = 10'd5;
    step();
    vectors++;
    if (b_Q !== 4'h5) begin
      miscompares++;
      $display("FAIL word5_kept: q=%h expected 5", b_Q);
    end
    b_A = 10'd6;
    step();
    vectors++;
    if (b_Q !== 4'h5 || b_BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL word6_kept: q=%h busy=%b expected q=5 busy=0", b_Q, b_BUSY);
    end
    b_S_n = 1'b1;
    step();
  endtask

  initial begin
    a_rst_n = 1'b0; a_A = '0; a_D = '0;
    a_S_n = 1'b1; a_W_n = 1'b1; a_G_n = 1'b0; a_R_n = 1'b1;
    b_rst_n = 1'b0; b_A = '0; b_D = '0;
    b_S_n = 1'b1; b_W_n = 1'b1; b_G_n = 1'b0; b_R_n = 1'b1;
    test_reset();
    test_write_read();
    test_output_enable();
    test_clear_drop();
    test_hold_clear();
    test_reset_midsweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/am9150_ram_sync.md
# am9150_ram_sync

Parametrised synchronous separate-I/O static RAM model, the clocked successor to the combinational AM9150 support part. It models an AM9150-style RAM: chip select, write enable, output enable and a memory-clear input. It adds:
- real storage
- registered reads with write-through
- a multi-cycle clear sequencer with a BUSY indication
- optional automatic clear after reset

It sits in the shared support library and stands in for the 1K×4 microcode/map RAMs (and wider/deeper variants) in CPU board models.

## Interface
Parameters:
- ADDR_WIDTH, 10: address bits; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 4: word width.
- CLEAR_VALUE, all zeros: value written by a clear sweep.
- CLEAR_ON_RESET, 1: 1 = a clear sweep starts automatically on reset release.

Ports:
- sysclk  in  1  clock, rising edge.
- sys_rst_n  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- A  in  ADDR_WIDTH  address.
- D  in  DATA_WIDTH  write data.
- S_n  in  1  chip select, active low.
- W_n  in  1  write enable, active low (qualified by S_n).
- G_n  in  1  output enable, active low, combinational.
- R_n  in  1  clear request, active low, level-sampled.
- Q  out  DATA_WIDTH  data out; high-Z when G_n=1.
- QV  out  1  Q register updated by the access accepted last cycle.
- BUSY  out  1  clear sweep in progress; accesses ignored.

## Operation
- FSM states: IDLE, CLEAR.
- IDLE, R_n=0 at an edge:
  - go to CLEAR with clear counter = 0.
  - Any same-cycle access is dropped: no write, QV=0 next cycle.
- IDLE, R_n=1, S_n=0, W_n=0: mem[A] <= D; Q register <= D (write-through); QV=1 next cycle.
- IDLE, R_n=1, S_n=0, W_n=1: Q register <= mem[A]; QV=1 next cycle.
- IDLE, S_n=1: no access; QV=0 next cycle; Q register holds.
- CLEAR:
  - Each cycle: mem[cnt] <= CLEAR_VALUE; cnt++.
  - When cnt = DEPTH-1 is written, return to IDLE.
  - S_n, W_n and R_n are ignored; QV=0; Q register holds.
- Clear held low: if R_n is still 0 in the first IDLE cycle after a sweep, a new sweep starts (level semantics).
- Q = Q register when G_n=0, else all-Z. G_n does not affect QV or storage.
- Memory contents are not affected by sys_rst_n itself; only a sweep clears them.

## Timing
- Reset values:
  - Q register = 0.
  - QV = 0.
  - cnt = 0.
  - State = CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - BUSY = CLEAR_ON_RESET.
- Read latency is 1 clock: address at edge N, data on Q and QV=1 after edge N.
- Write takes effect at edge N. A read of the same address at edge N+1 returns the new data.
- Back-to-back accesses every cycle are supported.
- A sweep is exactly DEPTH cycles.
- BUSY is registered and equals (state==CLEAR):
  - 1 from the edge that enters CLEAR.
  - 0 from the edge that writes word DEPTH-1.
- The counter wraps to 0 after DEPTH-1 and does not overflow into other logic.
- Reset asserted mid-sweep aborts the sweep immediately. Words not yet cleared keep their old content. With CLEAR_ON_RESET=1 the sweep restarts from 0 on release.
- Reset mid-access: the pending QV is forced to 0.

## Structure
- Package am9150_pkg: state typedef (IDLE, CLEAR) and a default clear-value constant.
- Sub-module am9150_clear_seq: owns the FSM, counter and BUSY. It outputs the clear address, a clear-write strobe and busy.
- The top level holds the array, access muxing, Q register, QV and the tristate.

## Test plan
- Reset with CLEAR_ON_RESET=1, ADDR_WIDTH=4 → BUSY=1 for exactly 16 cycles after release. Reads of all 16 addresses then return 0.
- Write 0xA to A=0x3FF, then read 0x3FF → QV=1 and Q=0xA one cycle after each access. Q=0xA on the write (write-through).
- G_n=1 during a read → Q is high-Z and QV=1. Drop G_n to 0 → Q=stored data in the same cycle.
- Fill 0x5 everywhere, pulse R_n low one cycle with a simultaneous write of 0x9 to A=7 → write dropped, BUSY for DEPTH cycles. Reading A=7 afterwards returns CLEAR_VALUE.
- Assert sys_rst_n mid-sweep at cnt=5 with CLEAR_ON_RESET=0 → BUSY=0 and QV=0 immediately. Word 4 reads cleared; word 6 keeps the old 0x5.
- Hold R_n low across two sweeps → BUSY stays 0 for exactly one IDLE cycle between sweeps. Accesses issued during the sweeps are ignored.
